instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program-counter and fetch stage directly upstream of the instruction memory.
//  Drives the 64-bit byte address each cycle and captures the returned 32-bit word with its PC
//  into a registered IF/ID output. The output is consumed by decode under a valid/ready handshake.
//  Accepts redirects (branch/jump targets) from execute; a redirect flushes the in-flight fetch.
// PARAMETERS
//  ADDR_WIDTH    64      instruction address width (bytes)
//  DATA_WIDTH    32      instruction word width
//  RESET_VECTOR  64'h0   PC loaded on reset
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           asynchronous, active-high reset
//  fetch_en_i     in   1           1 = fetching permitted
//  redirect_i     in   1           1 = load redirect_pc_i this cycle
//  redirect_pc_i  in   ADDR_WIDTH  redirect target
//  mem_addr_o     out  ADDR_WIDTH  address to instruction memory (combinational read)
//  mem_data_i     in   DATA_WIDTH  instruction word returned same cycle for mem_addr_o
//  if_valid_o     out  1           IF/ID entry valid
//  if_ready_i     in   1           decode accepts entry when if_valid_o && if_ready_i
//  if_pc_o        out  ADDR_WIDTH  PC of the held instruction
//  if_instr_o     out  DATA_WIDTH  held instruction
//  fetch_fault_o  out  1           misaligned redirect seen (FETCH_MISALIGN_TRAP_EN only, else tied 0)
// BEHAVIOUR
//  Reset: pc_q=RESET_VECTOR, state=IDLE, if_valid_o=0, if_pc_o=0, if_instr_o=NOP (32'h00000013), fetch_fault_o=0.
//  mem_addr_o = pc_q at all times. Zero added latency: word sampled the same cycle it is addressed.
//  FSM states and transitions:
//    IDLE: no capture. Goes to RUN when fetch_en_i=1.
//    RUN:  goes to IDLE when fetch_en_i=0.
//    TRAP: macro builds only.
//  Per-cycle priority in RUN:
//    1) redirect_i=1: pc_q<=redirect_pc_i; if_valid_o<=0 (flush, even if decode is handshaking).
//    2) else if (!if_valid_o || if_ready_i): if_pc_o<=pc_q; if_instr_o<=mem_data_i; if_valid_o<=1; pc_q<=pc_q+4.
//    3) else stall: pc_q and the IF/ID entry hold.
//  In IDLE:
//    - An unconsumed entry stays valid until handshaken; a handshake clears if_valid_o.
//    - redirect_i still loads pc_q and flushes.
//  pc_q+4 wraps modulo 2^ADDR_WIDTH (64'hFFFF_FFFF_FFFF_FFFC -> 0); no flag.
//  Redirect and fetch_en_i falling in the same cycle: redirect applied, then state goes IDLE.
//  Reset asserted mid-operation: all state returns to reset values immediately (async); no partial entry.
//  Redirect target low 2 bits without the macro: forced to 2'b00 before loading.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//    - redirect with redirect_pc_i[1:0]!=0 -> state TRAP, pc_q unchanged, if_valid_o<=0,
//      fetch_fault_o<=1 (sticky).
//    - TRAP is left only by rst.
//  Not defined: no TRAP state, fetch_fault_o tied 0, low bits forced to zero as above.
// STRUCTURE
//  riscv_pkg holds:
//    - XLEN=64, ILEN=32
//    - RISCV_NOP = 32'h00000013
//    - typedef enum logic [1:0] {FETCH_IDLE, FETCH_RUN, FETCH_TRAP} fetch_state_t
//    - typedef struct packed {pc; instr} if_id_t
//  One sub-module, if_id_reg: valid/ready register slice holding if_id_t, with load/flush/hold inputs.
//  PC register and FSM live in instr_fetch_unit.
// TESTING
//  1) Reset, fetch_en_i=1, if_ready_i=1, mem model word[i]=i
//     -> mem_addr_o 0,4,8,...; if_pc_o/if_instr_o lag by one cycle (0/0, 4/1, 8/2).
//  2) Drop if_ready_i for 3 cycles while valid at PC 8
//     -> if_pc_o=8 held and mem_addr_o=12 held; resumes with 12 on release.
//  3) redirect_i=1, redirect_pc_i=0x100 while valid && ready
//     -> next cycle if_valid_o=0 and mem_addr_o=0x100; following cycle if_pc_o=0x100.
//  4) Redirect to 64'hFFFF_FFFF_FFFF_FFFC, ready=1 -> captured PC ...FFFC, next mem_addr_o=0.
//  5) Redirect to 0x102
//     -> macro: fetch_fault_o=1, if_valid_o stays 0 until rst;
//     -> no macro: mem_addr_o=0x100.
//  6) fetch_en_i=0 with valid entry, ready=0 -> entry held, no new capture; ready=1 -> valid clears, pc_q unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch types and constants: widths, the canonical NOP,
// fetch FSM encoding and the IF/ID pipeline entry.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] RISCV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_TRAP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID valid/ready register slice: load captures a new entry, flush drops
// the valid bit, otherwise the entry holds.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_flush,
    input  if_id_t i_entry,
    output logic   o_valid,
    output if_id_t o_entry
);

    logic   r_valid;
    if_id_t r_entry;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_entry <= '{pc: '0, instr: RISCV_NOP};
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule

// File: rtl/instr_fetch_unit.sv
// PC register and fetch FSM feeding the IF/ID slice. Build with
// FETCH_MISALIGN_TRAP_EN to trap on misaligned redirects instead of masking them.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = XLEN,
    parameter int                    DATA_WIDTH   = ILEN,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  if_valid_o,
    input  logic                  if_ready_i,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic                  fetch_fault_o
);

    fetch_state_t          r_state;
    fetch_state_t          w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic                  w_misalign;
    logic                  w_load;
    logic                  w_flush;
    if_id_t                w_entry_d;
    if_id_t                w_entry_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misalign    = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign w_redirect_pc = redirect_pc_i;
`else
    assign w_misalign    = 1'b0;
    assign w_redirect_pc = redirect_pc_i & ~ADDR_WIDTH'(3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH_IDLE;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH_IDLE: if (w_misalign) w_next_state = FETCH_TRAP;
                        else if (fetch_en_i) w_next_state = FETCH_RUN;
            FETCH_RUN:  if (w_misalign) w_next_state = FETCH_TRAP;
                        else if (!fetch_en_i) w_next_state = FETCH_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
            FETCH_TRAP: w_next_state = FETCH_TRAP;
`endif
            default:    w_next_state = FETCH_IDLE;
        endcase
    end

    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        w_load    = 1'b0;
        w_flush   = 1'b0;
        w_pc_next = r_pc;
        if (r_state != FETCH_TRAP) begin
            if (redirect_i) begin
                w_flush = 1'b1;
                if (!w_misalign) w_pc_next = w_redirect_pc;
            end else if (r_state == FETCH_RUN && (!if_valid_o || if_ready_i)) begin
                w_load    = 1'b1;
                w_pc_next = r_pc + ADDR_WIDTH'(4);
            end else if (r_state == FETCH_IDLE && if_valid_o && if_ready_i) begin
                w_flush = 1'b1;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fault <= 1'b0;
        else if (w_misalign && r_state != FETCH_TRAP) r_fault <= 1'b1;
    end

    assign fetch_fault_o = r_fault;
`else
    assign fetch_fault_o = 1'b0;
`endif

    assign w_entry_d = '{pc: r_pc, instr: mem_data_i};

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_entry (w_entry_d),
        .o_valid (if_valid_o),
        .o_entry (w_entry_q)
    );

    assign mem_addr_o = r_pc;
    assign if_pc_o    = w_entry_q.pc;
    assign if_instr_o = w_entry_q.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural fetch model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic [63:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [63:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        fetch_fault_o;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: fetching mode, PC, held entry and sticky fault.
    logic        m_running;
    logic        m_trapped;
    logic [63:0] m_pc;
    logic        m_valid;
    logic [63:0] m_if_pc;
    logic [31:0] m_if_instr;
    logic        m_fault;

    always #5 clk = ~clk;

    // Memory image: word at byte address a is a/4.
    assign mem_data_i = 32'(mem_addr_o >> 2);

    instr_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en_i    (fetch_en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .fetch_fault_o (fetch_fault_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_running  = 1'b0;
        m_trapped  = 1'b0;
        m_pc       = 64'h0;
        m_valid    = 1'b0;
        m_if_pc    = 64'h0;
        m_if_instr = NOP;
        m_fault    = 1'b0;
    endtask

    task automatic model_update(input logic fe, input logic rd, input logic [63:0] rpc, input logic rdy);
        if (m_trapped) return;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (rd && rpc[1:0] != 2'b00) begin
            m_trapped = 1'b1;
            m_valid   = 1'b0;
            m_fault   = 1'b1;
            return;
        end
`endif
        if (rd) begin
            m_pc    = {rpc[63:2], 2'b00};
            m_valid = 1'b0;
        end else if (m_running && (!m_valid || rdy)) begin
            m_if_pc    = m_pc;
            m_if_instr = 32'(m_pc / 4);
            m_valid    = 1'b1;
            m_pc       = m_pc + 64'd4;
        end else if (!m_running && m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_running = fe;
    endtask

    task automatic compare_all();
        check("mem_addr", mem_addr_o, m_pc);
        check("if_valid", 64'(if_valid_o), 64'(m_valid));
        check("fault", 64'(fetch_fault_o), 64'(m_fault));
        if (m_valid) begin
            check("if_pc", if_pc_o, m_if_pc);
            check("if_instr", 64'(if_instr_o), 64'(m_if_instr));
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input logic fe, input logic rd, input logic [63:0] rpc, input logic rdy);
        fetch_en_i    = fe;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        if_ready_i    = rdy;
        model_update(fe, rd, rpc, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, 64'(if_valid_o), 64'd0);
        check({tag, "_addr"}, mem_addr_o, 64'h0);
        check({tag, "_pc"}, if_pc_o, 64'h0);
        check({tag, "_instr"}, 64'(if_instr_o), 64'(NOP));
        check({tag, "_fault"}, 64'(fetch_fault_o), 64'd0);
    endtask

    initial begin
        logic        fe, rd, rdy;
        logic [63:0] rpc;

        rst = 1'b1;
        fetch_en_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Sequential fetch: one idle cycle, then entries lag the address by a cycle.
        step(1, 0, 0, 1);
        check("t1_addr0", mem_addr_o, 64'h0);
        step(1, 0, 0, 1);
        check("t1_pc0", if_pc_o, 64'h0);
        check("t1_addr4", mem_addr_o, 64'h4);
        step(1, 0, 0, 1);
        check("t1_instr1", 64'(if_instr_o), 64'd1);
        step(1, 0, 0, 1);
        check("t1_pc8", if_pc_o, 64'h8);
        check("t1_instr2", 64'(if_instr_o), 64'd2);

        // Stall three cycles with PC 8 held.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            check("t2_hold_pc", if_pc_o, 64'h8);
            check("t2_hold_addr", mem_addr_o, 64'hC);
        end
        step(1, 0, 0, 1);
        check("t2_resume", if_pc_o, 64'hC);

        // Redirect during a handshake flushes the entry.
        step(1, 1, 64'h100, 1);
        check("t3_flush", 64'(if_valid_o), 64'd0);
        check("t3_addr", mem_addr_o, 64'h100);
        step(1, 0, 0, 1);
        check("t3_pc", if_pc_o, 64'h100);

        // PC wraps from the top of the address space.
        step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        step(1, 0, 0, 0);
        check("t4_pc", if_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t4_wrap", mem_addr_o, 64'h0);

        // Fetch disabled with an unconsumed entry, then drained.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t6_held", 64'(if_valid_o), 64'd1);
        check("t6_held_pc", if_pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 1);
        check("t6_drained", 64'(if_valid_o), 64'd0);
        check("t6_pc_kept", mem_addr_o, 64'h0);

        // Randomized traffic, with one asynchronous reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            fe  = ($urandom_range(9) != 0);
            rd  = ($urandom_range(9) == 0);
            rdy = ($urandom_range(9) < 7);
            rpc = {$urandom, $urandom};
            if ($urandom_range(3) == 0) rpc[63:8] = '1;
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc[1:0] = 2'b00;
`endif
            step(fe, rd, rpc, rdy);
            if (i == 200) begin
                #2 rst = 1'b1;
                #1 check_reset_values("async_rst");
                model_reset();
                #1 rst = 1'b0;
            end
        end

        // Misaligned redirect: trap with the macro, masked target without it.
        step(1, 1, 64'h100, 1);
        step(1, 0, 0, 1);
        step(1, 1, 64'h102, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("t5_fault", 64'(fetch_fault_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1);
            check("t5_trap_valid", 64'(if_valid_o), 64'd0);
        end
`else
        check("t5_masked", mem_addr_o, 64'h100);
        step(1, 0, 0, 1);
        check("t5_masked_pc", if_pc_o, 64'h100);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
